// File: rtl/dma_transfer_splitter.sv
// Splits one large DRAM transfer command into CHUNK_BYTES-sized requests for dma_engine,
// limits chunks in flight, counts completions and reports the command's cycle count.
module dma_transfer_splitter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int LEN_WIDTH    = 32,
   parameter int CHUNK_BYTES  = 4096,
   parameter int MAX_INFLIGHT = 8,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_length,
   output logic                  dma_issue_valid,
   input  logic                  dma_issue_ready,
   output logic [ADDR_WIDTH-1:0] dma_issue_base_addr,
   output logic [LEN_WIDTH-1:0]  dma_issue_length,
   input  logic                  dma_done_valid,
   output logic                  busy,
   output logic                  cmd_done,
   output logic [CNT_WIDTH-1:0]  cmd_cycles,
   output logic [LEN_WIDTH-1:0]  chunks_issued,
   output logic [LEN_WIDTH-1:0]  chunks_done,
   output logic                  err_spurious_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [LEN_WIDTH:0]    CHUNK_WIDE   = (LEN_WIDTH+1)'(CHUNK_BYTES);
   localparam logic [LEN_WIDTH:0]    CHUNK_M1     = (LEN_WIDTH+1)'(CHUNK_BYTES - 1);
   localparam logic [LEN_WIDTH-1:0]  CHUNK_LEN    = LEN_WIDTH'(CHUNK_BYTES);
   localparam logic [ADDR_WIDTH-1:0] CHUNK_ADDR   = ADDR_WIDTH'(CHUNK_BYTES);
   localparam logic [LEN_WIDTH-1:0]  INFLIGHT_LIM = LEN_WIDTH'(MAX_INFLIGHT);

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [LEN_WIDTH-1:0]  total;
   logic [CNT_WIDTH-1:0]  cycle_cnt;
   logic [LEN_WIDTH-1:0]  inflight;
   logic [LEN_WIDTH-1:0]  issue_len;
   logic [LEN_WIDTH-1:0]  done_next;
   logic [CNT_WIDTH-1:0]  cycle_next;
   logic                  issue_fire;
   logic                  last_issue;
   logic                  count_done;

   // Everything below is decoded from registered state only, so issue_valid never looks at ready.
   assign inflight            = chunks_issued - chunks_done;
   assign issue_len           = (remaining < CHUNK_LEN) ? remaining : CHUNK_LEN;
   assign dma_issue_valid     = (state == ISSUE) && (inflight < INFLIGHT_LIM);
   assign dma_issue_base_addr = cur_addr;
   assign dma_issue_length    = issue_len;
   assign issue_fire          = dma_issue_valid && dma_issue_ready;
   assign last_issue          = (chunks_issued + LEN_WIDTH'(1)) == total;
   assign cmd_ready           = (state == IDLE);
   assign busy                = (state != IDLE);
   assign cmd_done            = (state == DONE);

   // Completions only count while a command is live; anything past total in DRAIN is spurious.
   assign count_done = dma_done_valid &&
                       ((state == ISSUE) || ((state == DRAIN) && (chunks_done < total)));
   assign done_next  = chunks_done + LEN_WIDTH'(count_done);
   assign cycle_next = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         cur_addr          <= '0;
         remaining         <= '0;
         total             <= '0;
         cycle_cnt         <= '0;
         cmd_cycles        <= '0;
         chunks_issued     <= '0;
         chunks_done       <= '0;
         err_spurious_done <= 1'b0;
      end else begin
         if (dma_done_valid && !count_done)
            err_spurious_done <= 1'b1;
         chunks_done <= done_next;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cur_addr      <= cmd_base_addr;
                  remaining     <= cmd_length;
                  // Wide ceil-divide so lengths near all-ones cannot overflow the rounding add.
                  total         <= LEN_WIDTH'(({1'b0, cmd_length} + CHUNK_M1) / CHUNK_WIDE);
                  chunks_issued <= '0;
                  chunks_done   <= '0;
                  cycle_cnt     <= '0;
                  state         <= (cmd_length == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               cycle_cnt <= cycle_next;
               if (issue_fire) begin
                  cur_addr      <= cur_addr + CHUNK_ADDR;
                  remaining     <= remaining - issue_len;
                  chunks_issued <= chunks_issued + LEN_WIDTH'(1);
                  if (last_issue)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               cycle_cnt <= cycle_next;
               if (done_next == total)
                  state <= DONE;
            end
            DONE: begin
               cmd_cycles <= cycle_cnt;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
